// File: rtl/record_fifo_if.sv
// rtl/record_fifo_if.sv - word-in / record-out handshake and status bundle for record_fifo
interface record_fifo_if #(
  parameter int WordSize = 8,
  parameter int RecordWords = 16,
  parameter int Depth = 8
);
  localparam int RecordSizeBits = WordSize * RecordWords;
  localparam int StoragePosSize = $clog2(Depth * RecordWords);

  logic                      in_valid;
  logic [WordSize-1:0]       in_data;
  logic                      in_ready;
  logic                      flush;
  logic                      out_valid;
  logic [RecordSizeBits-1:0] out_data;
  logic                      out_ready;
  logic [StoragePosSize:0]   word_count;
  logic [$clog2(Depth):0]    record_count;
  logic                      almost_full;
  logic                      overrun;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, word_count, record_count, almost_full, overrun
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, word_count, record_count, almost_full, overrun
  );
endinterface

// File: rtl/record_fifo.sv
// rtl/record_fifo.sv - assembles RecordWords input words into records behind a registered output stage
// Optional sticky write-while-full flag enabled by RECORD_FIFO_OVERRUN_EN.
module record_fifo #(
  parameter int WordSize = 8,
  parameter int RecordWords = 16,
  parameter int Depth = 8,
  parameter int AlmostFullRecords = Depth - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  record_fifo_if.slave bus
);
  localparam int RecordSizeBits = WordSize * RecordWords;
  localparam int StorageSize = Depth * RecordWords;
  localparam int StoragePosSize = $clog2(StorageSize);
  localparam int PtrW = StoragePosSize + 1;
  localparam int RecShift = $clog2(RecordWords);
  localparam int CountW = $clog2(Depth) + 1;
  localparam logic [PtrW-1:0] FullWords = PtrW'(StorageSize);
  localparam logic [PtrW-1:0] AfWords = PtrW'(AlmostFullRecords * RecordWords);
  localparam logic [PtrW-1:0] RecWords = PtrW'(RecordWords);

  logic [WordSize-1:0]       storage_q [StorageSize];
  logic [PtrW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic                      out_valid_q, out_valid_d;
  logic [RecordSizeBits-1:0] out_data_q, out_data_d, rec;
  logic [PtrW-1:0]           word_count;
  logic                      in_ready, wr_en, load;

  assign word_count = wp_q - rp_q;
  assign in_ready   = !bus.flush && (word_count != FullWords);
  assign wr_en      = bus.in_valid && in_ready;
  assign load       = (!out_valid_q || bus.out_ready) && (word_count >= RecWords);

  // rp is always record-aligned, so a record never crosses the storage wrap point
  always_comb begin
    rec = '0;
    for (int i = 0; i < RecordWords; i++) begin
      rec[i*WordSize +: WordSize] = storage_q[rp_q[StoragePosSize-1:0] + StoragePosSize'(i)];
    end
  end

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (bus.flush) begin
      wp_d        = '0;
      rp_d        = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_en) begin
        wp_d = wp_q + PtrW'(1);
      end
      if (load) begin
        rp_d        = rp_q + RecWords;
        out_valid_d = 1'b1;
        out_data_d  = rec;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q        <= '0;
      rp_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      storage_q[wp_q[StoragePosSize-1:0]] <= bus.in_data;
    end
  end

`ifdef RECORD_FIFO_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (bus.flush) begin
      overrun_d = 1'b0;
    end else if (bus.in_valid && !in_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.word_count   = word_count;
  assign bus.record_count = word_count[PtrW-1:RecShift] + CountW'(out_valid_q);
  assign bus.almost_full  = (word_count >= AfWords);
endmodule
